// File: rtl/cp0_vec_intc_if.sv
// Pipeline-side bundle for the vectored CP0: register access, interrupt lines and redirect.
// The master (pipeline) drives requests; the slave (CP0) returns read data and jump control.
interface cp0_vec_intc_if #(
    parameter int NUM_IRQ = 8,
    parameter int DATA_W  = 32
);
    logic [1:0]         oper;
    logic [4:0]         addr_r;
    logic [DATA_W-1:0]  data_r;
    logic [4:0]         addr_w;
    logic [DATA_W-1:0]  data_w;
    logic               ir_en;
    logic [NUM_IRQ-1:0] ir_in;
    logic [DATA_W-1:0]  ret_addr;
    logic               jump_en;
    logic [DATA_W-1:0]  jump_addr;
    logic               irq_active;
    logic [3:0]         irq_id;

    modport master (
        output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
        input  data_r, jump_en, jump_addr, irq_active, irq_id
    );

    modport slave (
        input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
        output data_r, jump_en, jump_addr, irq_active, irq_id
    );
endinterface

// File: rtl/cp0_vec_intc.sv
// Vectored CP0: edge-latched, IM-masked interrupts with fixed-priority arbitration,
// EPC save/restore, ERET and an EXL flag that blocks nesting.
module cp0_vec_intc #(
    parameter int NUM_IRQ   = 8,
    parameter int VEC_SHIFT = 4,
    parameter int DATA_W    = 32
) (
    input logic          clk,
    input logic          rst,
    cp0_vec_intc_if.slave bus
);
    localparam logic [1:0] CP_STORE = 2'b01;
    localparam logic [1:0] CP_ERET  = 2'b10;

    localparam logic [4:0] A_EHBR   = 5'd1;
    localparam logic [4:0] A_EPC    = 5'd2;
    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;

    logic [DATA_W-1:0]  ehbr_q, ehbr_d;
    logic [DATA_W-1:0]  epc_q, epc_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [3:0]         idx_q, idx_d;
    logic [DATA_W-1:0]  data_r_q, data_r_d;

    logic [NUM_IRQ-1:0] masked;
    logic [NUM_IRQ-1:0] win_oh;
    logic [NUM_IRQ-1:0] rise;
    logic [3:0]         win_idx;
    logic               req;
    logic               is_eret;
    logic               is_store;
    logic [DATA_W-1:0]  status_rd;
    logic [DATA_W-1:0]  cause_rd;

    // Lowest set index wins; scanning downward leaves the smallest index last.
    always_comb begin
        masked  = pend_q & im_q;
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) win_idx = 4'(i);
        end
        win_oh   = NUM_IRQ'(1) << win_idx;
        rise     = bus.ir_in & ~hist_q;
        req      = bus.ir_en & ie_q & ~exl_q & (|masked);
        is_eret  = (bus.oper == CP_ERET);
        is_store = (bus.oper == CP_STORE);
    end

    always_comb begin
        bus.jump_en   = req | is_eret;
        bus.jump_addr = '0;
        if (req) begin
            bus.jump_addr = ehbr_q + (DATA_W'(win_idx) << VEC_SHIFT);
        end else if (is_eret) begin
            bus.jump_addr = epc_q;
        end
    end

    always_comb begin
        status_rd                 = '0;
        status_rd[0]              = ie_q;
        status_rd[1]              = exl_q;
        status_rd[8 +: NUM_IRQ]   = im_q;
        cause_rd                  = '0;
        cause_rd[3:0]             = idx_q;
        cause_rd[8 +: NUM_IRQ]    = pend_q;
        case (bus.addr_r)
            A_EHBR:   data_r_d = ehbr_q;
            A_EPC:    data_r_d = epc_q;
            A_STATUS: data_r_d = status_rd;
            A_CAUSE:  data_r_d = cause_rd;
            default:  data_r_d = '0;
        endcase
    end

    // Accept pre-empts ERET, which pre-empts STORE; new edges are OR-ed in last so they survive a clear.
    always_comb begin
        ehbr_d = ehbr_q;
        epc_d  = epc_q;
        ie_d   = ie_q;
        exl_d  = exl_q;
        im_d   = im_q;
        pend_d = pend_q;
        idx_d  = idx_q;
        hist_d = bus.ir_in;
        if (req) begin
            epc_d  = bus.ret_addr;
            exl_d  = 1'b1;
            idx_d  = win_idx;
            pend_d = pend_q & ~win_oh;
        end else if (is_eret) begin
            exl_d = 1'b0;
        end else if (is_store) begin
            case (bus.addr_w)
                A_EHBR:   ehbr_d = bus.data_w;
                A_EPC:    epc_d  = bus.data_w;
                A_STATUS: begin
                    ie_d  = bus.data_w[0];
                    exl_d = bus.data_w[1];
                    im_d  = bus.data_w[8 +: NUM_IRQ];
                end
                A_CAUSE:  pend_d = pend_q & ~bus.data_w[8 +: NUM_IRQ];
                default:  ;
            endcase
        end
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ehbr_q   <= '0;
            epc_q    <= '0;
            ie_q     <= 1'b0;
            exl_q    <= 1'b0;
            im_q     <= '0;
            pend_q   <= '0;
            hist_q   <= '0;
            idx_q    <= '0;
            data_r_q <= '0;
        end else begin
            ehbr_q   <= ehbr_d;
            epc_q    <= epc_d;
            ie_q     <= ie_d;
            exl_q    <= exl_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            hist_q   <= hist_d;
            idx_q    <= idx_d;
            data_r_q <= data_r_d;
        end
    end

    assign bus.data_r     = data_r_q;
    assign bus.irq_active = exl_q;
    assign bus.irq_id     = idx_q;
endmodule

// File: doc/cp0_vec_intc.md
Name: cp0_vec_intc

Overview:
Parametrised successor to the single-line CP0 for the MIPS pipeline. Latches up to NUM_IRQ edge-triggered external interrupt lines and masks them through STATUS. Arbitrates by fixed priority and issues vectored jumps to EHBR + (index << VEC_SHIFT). Saves and restores EPC, supports MTC0/MFC0 and ERET, and blocks re-entry with an EXL flag. Reads occur in ID, writes and ERET in EXE, interrupt acceptance in MEM.

Parameters:
NUM_IRQ, 8, number of external interrupt lines (1..16)
VEC_SHIFT, 4, log2 of the byte spacing between interrupt vectors
DATA_W, 32, register and address width

Ports:
clk  in  1  main clock
rst  in  1  asynchronous reset, active-high
oper  in  2  CP0 operation, encoded per mips_define.vh (EXE_CP_NONE, EXE_CP_STORE, EXE_CP0_ERET); the fourth code behaves as NONE
addr_r  in  5  read register address
data_r  out  DATA_W  read data, registered
addr_w  in  5  write register address
data_w  in  DATA_W  write data
ir_en  in  1  MEM stage holds a valid instruction that may be interrupted
ir_in  in  NUM_IRQ  external interrupt lines, rising-edge sensitive
ret_addr  in  DATA_W  address saved to EPC on acceptance
jump_en  out  1  forced redirect (interrupt accept or ERET), combinational
jump_addr  out  DATA_W  redirect target, combinational
irq_active  out  1  mirrors STATUS.EXL
irq_id  out  4  index of the most recently accepted interrupt

Behaviour:
- Register map:
  - 1 = EHBR: read/write.
  - 2 = EPC: read/write.
  - 12 = STATUS: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM; other bits read 0.
  - 13 = CAUSE: bits[8+NUM_IRQ-1:8] IP pending, read-only except write-1-to-clear; bits[3:0] last accepted index, read-only.
  - All other addresses read 0 and ignore writes.
- Reset, asynchronous: all registers 0, pending 0, edge-history 0, data_r 0, irq_id 0. jump_en and jump_addr follow from the zero state (0 unless oper=ERET).
- Edge detection: keep a one-cycle history of ir_in. pending[i] sets when ir_in[i] was 0 last cycle and is 1 this cycle. Level-held lines do not re-trigger.
- Request: req = ir_en & IE & ~EXL & |(pending & IM). Winner = lowest set index of (pending & IM).
- Accept cycle (req=1):
  - jump_en=1, jump_addr = EHBR + (winner << VEC_SHIFT), wrapping modulo 2^DATA_W.
  - At the clock edge: EPC<=ret_addr, EXL<=1, CAUSE[3:0]<=winner, irq_id<=winner, pending[winner]<=0.
- ERET (oper=ERET, req=0): jump_en=1, jump_addr=EPC, combinational. At the clock edge EXL<=0. EPC is unchanged.
- STORE (oper=STORE, req=0): writes per the map at the clock edge.
  - STATUS write replaces IE, EXL and IM.
  - CAUSE write clears IP bits where data_w has 1.
- Priority among events in one cycle: interrupt accept > ERET > STORE.
  - On accept, oper is ignored because the pipeline flushes that instruction.
  - A new edge on pending[i] in the same cycle that clears pending[i] (accept or W1C) wins: the bit stays set.
- Nesting: none. While EXL=1, pending bits keep accumulating but no accept occurs until ERET, or until software clears EXL.
- Read: data_r <= reg[addr_r] every cycle (1-cycle latency), value taken before the same-edge write. No bypass; the pipeline's hazard logic covers read-after-write.
- Otherwise jump_en=0 and jump_addr=0.
- Reset mid-handler: EXL, pending and EPC all return to 0 immediately; no jump is issued afterwards.

Test Plan:
1. Reset, write EHBR=0x100, STATUS=0x0000FF01, pulse ir_in[3] with ir_en=1, ret_addr=0x40 -> jump_en=1 with jump_addr=0x130 in the accept cycle; next cycle EPC=0x40, CAUSE[3:0]=3, irq_active=1, IP bit 11 clear.
2. Lines 2 and 5 rise in the same cycle while EXL=1 -> no jump. ERET -> jump_addr=EPC and EXL=0. Next cycle accepts line 2 (jump 0x120). After the second ERET, line 5 is accepted (0x150).
3. IM masks line 4 (STATUS=0x0000EF01) and line 4 pulses -> CAUSE IP bit 12 set, no jump. Writing CAUSE=0x1000 clears it. Unmasking afterwards produces no jump.
4. ir_in[0] held high for 20 cycles -> exactly one pending and one accept.
5. Accept while oper=STORE to EHBR -> EHBR unchanged. Accept coinciding with ERET -> vector jump, EXL=1.
6. Assert rst asynchronously mid-handler (EXL=1, pending=0x24) -> all registers 0 before the next clk edge, irq_active=0, jump_en=0.
